// File: rtl/tpu_tile_sched_if.sv
// rtl/tpu_tile_sched_if.sv - tile descriptor stream and writeback-complete pulse between scheduler and array
interface tpu_tile_sched_if #(
    parameter int ADDR_W = 8
);
    logic              tile_valid;
    logic              tile_ready;
    logic [ADDR_W-1:0] tile_a_base;
    logic [ADDR_W-1:0] tile_b_base;
    logic [ADDR_W-1:0] tile_o_base;
    logic [2:0]        tile_rows;
    logic [2:0]        tile_cols;
    logic [2:0]        tile_klen;
    logic              tile_first_k;
    logic              tile_last_k;
    logic              wb_done;

    modport master (
        output tile_valid, tile_a_base, tile_b_base, tile_o_base,
        output tile_rows, tile_cols, tile_klen, tile_first_k, tile_last_k,
        input  tile_ready, wb_done
    );

    modport slave (
        input  tile_valid, tile_a_base, tile_b_base, tile_o_base,
        input  tile_rows, tile_cols, tile_klen, tile_first_k, tile_last_k,
        output tile_ready, wb_done
    );
endinterface

// File: rtl/tpu_tile_sched.sv
// rtl/tpu_tile_sched.sv - walks output tiles and k-steps of an m x k by k x n matmul for the 4x4 array
module tpu_tile_sched #(
    parameter int ARRAY_DIM = 4,
    parameter int DIM_W     = 4,
    parameter int ADDR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIM_W-1:0] m,
    input  logic [DIM_W-1:0] n,
    input  logic [DIM_W-1:0] k,
    tpu_tile_sched_if.master tile_if,
    output logic             busy,
    output logic             done,
    output logic [6:0]       tiles_issued
);
    // One extra bit so offset+step never wraps when compared against a dimension.
    localparam int EXT_W = DIM_W + 1;
    localparam logic [EXT_W-1:0] STEP = EXT_W'(ARRAY_DIM);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_WB, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [DIM_W-1:0]  m_q, m_d, n_q, n_d, k_q, k_d;
    logic [EXT_W-1:0]  row_off_q, row_off_d;   // row_tile*4
    logic [EXT_W-1:0]  col_off_q, col_off_d;   // col_tile*4
    logic [EXT_W-1:0]  k_base_q, k_base_d;
    logic [ADDR_W-1:0] a_row_q, a_row_d;       // row_tile*k
    logic [ADDR_W-1:0] b_col_q, b_col_d;       // col_tile*k
    logic [ADDR_W-1:0] o_col_q, o_col_d;       // col_tile*m
    logic [6:0]        tiles_q, tiles_d;

    logic last_k, last_row, last_col, issuing;

    function automatic logic [2:0] extent(input logic [EXT_W-1:0] rem);
        if (rem >= STEP) return 3'(ARRAY_DIM);
        return rem[2:0];
    endfunction

    assign issuing  = (state_q == S_ISSUE);
    assign last_k   = (k_base_q + STEP) >= {1'b0, k_q};
    assign last_row = (row_off_q + STEP) >= {1'b0, m_q};
    assign last_col = (col_off_q + STEP) >= {1'b0, n_q};

    // Descriptor fields are forced to zero whenever no descriptor is offered.
    assign tile_if.tile_valid   = issuing;
    assign tile_if.tile_a_base  = issuing ? a_row_q + ADDR_W'(k_base_q) : '0;
    assign tile_if.tile_b_base  = issuing ? b_col_q + ADDR_W'(k_base_q) : '0;
    assign tile_if.tile_o_base  = issuing ? o_col_q + ADDR_W'(row_off_q) : '0;
    assign tile_if.tile_rows    = issuing ? extent({1'b0, m_q} - row_off_q) : '0;
    assign tile_if.tile_cols    = issuing ? extent({1'b0, n_q} - col_off_q) : '0;
    assign tile_if.tile_klen    = issuing ? extent({1'b0, k_q} - k_base_q) : '0;
    assign tile_if.tile_first_k = issuing && (k_base_q == '0);
    assign tile_if.tile_last_k  = issuing && last_k;

    assign busy         = (state_q == S_ISSUE) || (state_q == S_WAIT_WB);
    assign done         = (state_q == S_DONE);
    assign tiles_issued = tiles_q;

    // Next-state: latch job, step k within a tile, then row/col tiles after writeback.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        n_d       = n_q;
        k_d       = k_q;
        row_off_d = row_off_q;
        col_off_d = col_off_q;
        k_base_d  = k_base_q;
        a_row_d   = a_row_q;
        b_col_d   = b_col_q;
        o_col_d   = o_col_q;
        tiles_d   = tiles_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d       = m;
                    n_d       = n;
                    k_d       = k;
                    row_off_d = '0;
                    col_off_d = '0;
                    k_base_d  = '0;
                    a_row_d   = '0;
                    b_col_d   = '0;
                    o_col_d   = '0;
                    tiles_d   = '0;
                    state_d   = (m != '0 && n != '0 && k != '0) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                if (tile_if.tile_ready) begin
                    tiles_d = tiles_q + 7'd1;
                    if (last_k) state_d = S_WAIT_WB;
                    else        k_base_d = k_base_q + STEP;
                end
            end
            S_WAIT_WB: begin
                if (tile_if.wb_done) begin
                    k_base_d = '0;
                    state_d  = S_ISSUE;
                    if (!last_row) begin
                        row_off_d = row_off_q + STEP;
                        a_row_d   = a_row_q + ADDR_W'(k_q);
                    end else begin
                        row_off_d = '0;
                        a_row_d   = '0;
                        if (last_col) begin
                            state_d = S_DONE;
                        end else begin
                            col_off_d = col_off_q + STEP;
                            b_col_d   = b_col_q + ADDR_W'(k_q);
                            o_col_d   = o_col_q + ADDR_W'(m_q);
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and accumulator registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            n_q       <= '0;
            k_q       <= '0;
            row_off_q <= '0;
            col_off_q <= '0;
            k_base_q  <= '0;
            a_row_q   <= '0;
            b_col_q   <= '0;
            o_col_q   <= '0;
            tiles_q   <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            n_q       <= n_d;
            k_q       <= k_d;
            row_off_q <= row_off_d;
            col_off_q <= col_off_d;
            k_base_q  <= k_base_d;
            a_row_q   <= a_row_d;
            b_col_q   <= b_col_d;
            o_col_q   <= o_col_d;
            tiles_q   <= tiles_d;
        end
    end
endmodule

// File: tb/tb_tpu_tile_sched.sv
// tb/tb_tpu_tile_sched.sv - scoreboard bench for tpu_tile_sched with randomized ready/writeback timing
module tb_tpu_tile_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] m = '0, n = '0, k = '0;
    logic       busy, done;
    logic [6:0] tiles_issued;

    int total = 0;
    int bad = 0;

    typedef struct {
        int a, b, o, rows, cols, klen, first, last, idx;
    } desc_t;
    desc_t exp_q[$];
    desc_t e;

    logic        held = 1'b0;
    logic [42:0] snap;

    tpu_tile_sched_if #(.ADDR_W(8)) tif ();

    tpu_tile_sched #(.ARRAY_DIM(4), .DIM_W(4), .ADDR_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .m            (m),
        .n            (n),
        .k            (k),
        .tile_if      (tif.master),
        .busy         (busy),
        .done         (done),
        .tiles_issued (tiles_issued)
    );

    always #5 clk = ~clk;

    function automatic int imin(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    function automatic logic [42:0] cur_fields();
        return {tif.tile_valid, tif.tile_a_base, tif.tile_b_base, tif.tile_o_base,
                tif.tile_rows, tif.tile_cols, tif.tile_klen, tif.tile_first_k,
                tif.tile_last_k, tiles_issued};
    endfunction

    task automatic check(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Reference: enumerate the job directly from the loop-order rules.
    function automatic int model_push(input int mm, input int nn, input int kk);
        desc_t d;
        int cnt = 0;
        if (mm == 0 || nn == 0 || kk == 0) return 0;
        for (int ct = 0; ct * 4 < nn; ct++)
            for (int rt = 0; rt * 4 < mm; rt++)
                for (int kb = 0; kb < kk; kb += 4) begin
                    d.a = rt * kk + kb;
                    d.b = ct * kk + kb;
                    d.o = ct * mm + rt * 4;
                    d.rows = imin(4, mm - 4 * rt);
                    d.cols = imin(4, nn - 4 * ct);
                    d.klen = imin(4, kk - kb);
                    d.first = (kb == 0);
                    d.last = (kb + 4 >= kk);
                    d.idx = cnt;
                    exp_q.push_back(d);
                    cnt++;
                end
        return cnt;
    endfunction

    // Monitor: pops the scoreboard on each handshake and checks stability under backpressure.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                total++;
                if (cur_fields() != snap) begin
                    bad++;
                    $display("FAIL stall_stable: got %h expected %h", cur_fields(), snap);
                end
            end
            if (tif.tile_valid && tif.tile_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_tile: got a=%0d b=%0d o=%0d expected none",
                             tif.tile_a_base, tif.tile_b_base, tif.tile_o_base);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(tif.tile_a_base) != e.a || int'(tif.tile_b_base) != e.b ||
                        int'(tif.tile_o_base) != e.o || int'(tif.tile_rows) != e.rows ||
                        int'(tif.tile_cols) != e.cols || int'(tif.tile_klen) != e.klen ||
                        int'(tif.tile_first_k) != e.first || int'(tif.tile_last_k) != e.last ||
                        int'(tiles_issued) != e.idx) begin
                        bad++;
                        $display("FAIL tile_desc: got a%0d b%0d o%0d r%0d c%0d k%0d f%0d l%0d n%0d expected a%0d b%0d o%0d r%0d c%0d k%0d f%0d l%0d n%0d",
                                 tif.tile_a_base, tif.tile_b_base, tif.tile_o_base, tif.tile_rows,
                                 tif.tile_cols, tif.tile_klen, tif.tile_first_k, tif.tile_last_k,
                                 tiles_issued, e.a, e.b, e.o, e.rows, e.cols, e.klen, e.first,
                                 e.last, e.idx);
                    end
                end
            end
            held = tif.tile_valid && !tif.tile_ready;
            snap = cur_fields();
        end
    end

    // rmode: 0 ready always, 1 random ready, 2 stall the second descriptor for 3 cycles.
    task automatic run_job(input int mm, input int nn, input int kk, input int rmode, input bit poke);
        int nexp, exp_wb, hs, stall, cyc, nwb, dly;
        bit saw_hs, saw_last;
        nexp = model_push(mm, nn, kk);
        exp_wb = (nexp == 0) ? 0 : ((mm + 3) / 4) * ((nn + 3) / 4);
        tif.tile_ready = 1'b0;
        m = 4'(mm); n = 4'(nn); k = 4'(kk); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (nexp == 0) begin
            check("zero_done", done, 1);
            check("zero_busy", busy, 0);
            check("zero_valid", tif.tile_valid, 0);
            @(posedge clk); #1;
            check("zero_done_clear", done, 0);
            check("zero_valid_after", tif.tile_valid, 0);
            return;
        end
        check("start_busy", busy, 1);
        check("start_valid", tif.tile_valid, 1);
        hs = 0; stall = 0; cyc = 0; nwb = 0;
        while (!done && cyc < 3000) begin
            case (rmode)
                0: tif.tile_ready = 1'b1;
                1: tif.tile_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    tif.tile_ready = !(hs == 1 && stall < 3);
                    if (!tif.tile_ready && tif.tile_valid) stall++;
                end
            endcase
            if (poke && cyc == 2) begin
                start = 1'b1; m = 4'd2; n = 4'd2; k = 4'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            saw_hs = tif.tile_valid && tif.tile_ready;
            saw_last = tif.tile_last_k;
            @(posedge clk); #1;
            cyc++;
            if (saw_hs) hs++;
            if (saw_hs && saw_last) begin
                start = 1'b0;
                tif.tile_ready = 1'($urandom_range(0, 1));
                dly = $urandom_range(0, 4);
                for (int i = 0; i < dly; i++) begin
                    check("wait_wb_valid", tif.tile_valid, 0);
                    @(posedge clk); #1;
                    cyc++;
                end
                check("wait_wb_busy", busy, 1);
                tif.wb_done = 1'b1;
                @(posedge clk); #1;
                tif.wb_done = 1'b0;
                nwb++;
            end
        end
        start = 1'b0;
        check("job_done", done, 1);
        check("job_busy_low", busy, 0);
        check("job_tiles_issued", tiles_issued, nexp);
        check("job_wb_count", nwb, exp_wb);
        check("job_queue_empty", exp_q.size(), 0);
        if (rmode == 2) check("stall_cycles", stall, 3);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int nexp, rm, rn, rk;
        tif.tile_ready = 1'b0;
        tif.wb_done = 1'b0;
        #1;
        check("rst_valid", tif.tile_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tiles", tiles_issued, 0);
        check("rst_fields", {tif.tile_a_base, tif.tile_b_base, tif.tile_o_base, tif.tile_rows,
                             tif.tile_cols, tif.tile_klen, tif.tile_first_k, tif.tile_last_k}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_job(4, 4, 4, 0, 0);
        run_job(5, 6, 9, 0, 0);
        run_job(5, 6, 9, 2, 0);
        run_job(3, 3, 0, 0, 0);
        run_job(5, 6, 9, 1, 1);
        run_job(15, 15, 15, 1, 0);

        nexp = model_push(4, 4, 4);
        tif.tile_ready = 1'b1;
        m = 4'd4; n = 4'd4; k = 4'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_tiles", tiles_issued, nexp);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", tif.tile_valid, 0);
        check("mid_rst_tiles", tiles_issued, 0);
        check("mid_rst_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tif.wb_done = 1'b1;
        @(posedge clk); #1;
        tif.wb_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stray_wb_idle", {busy, done, tif.tile_valid}, 0);
            @(posedge clk); #1;
        end
        run_job(4, 4, 4, 0, 0);

        for (int j = 0; j < 6; j++) begin
            rm = $urandom_range(1, 15);
            rn = $urandom_range(1, 15);
            rk = $urandom_range(0, 15);
            run_job(rm, rn, rk, 1, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
